// File: rtl/uncache_ctrl_if.sv
// Single-beat AXI-lite-style bus used by the uncached access controller.
//   master : controller side (drives ar/aw/w channels, rready, bready)
//   slave  : bus arbiter / memory side
interface uncache_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              arready;

    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              rready;

    logic              awvalid;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic              awready;

    logic              wvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wready;

    logic              bvalid;
    logic              bready;

    modport master (
        output arvalid, araddr, arsize,
        input  arready,
        input  rvalid, rdata,
        output rready,
        output awvalid, awaddr, awsize,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arsize,
        output arready,
        output rvalid, rdata,
        input  rready,
        input  awvalid, awaddr, awsize,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/uncache_ctrl.sv
// Uncached data access controller: turns one uncached MEM-stage access into a
// single-beat bus read or write and stalls the pipeline until it completes.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   cpu_req_valid      access presented by MEM stage
//   cpu_is_uncache     access classified uncached (others are ignored)
//   cpu_wr             1=store, 0=load
//   cpu_addr/wdata/wstrb/size   request fields, latched on acceptance
//   cpu_stall          combinational pipeline hold
//   cpu_rdata          registered load data, held until the next load completes
//   cpu_rdata_valid    one-cycle completion pulse
//   bus                AXI-lite-style master port
module uncache_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cpu_req_valid,
    input  logic                cpu_is_uncache,
    input  logic                cpu_wr,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    input  logic [1:0]          cpu_size,
    output logic                cpu_stall,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_rdata_valid,
    uncache_ctrl_if.master      bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              accept;

    assign accept = cpu_req_valid & cpu_is_uncache;

    // State and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            size_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            size_q        <= size_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        size_d        = size_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    wstrb_d = cpu_wstrb;
                    size_d  = cpu_size;
                    if (cpu_wr) begin
                        state_d   = WR_AWW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            RD_AR: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (bus.rvalid) begin
                    rready_d      = 1'b0;
                    rdata_d       = bus.rdata;
                    rdata_valid_d = 1'b1;
                    state_d       = DONE;
                end
            end
            WR_AWW: begin
                // A cleared awvalid/wvalid marks that channel's handshake as done
                if (bus.awready) awvalid_d = 1'b0;
                if (bus.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (bus.bvalid) begin
                    bready_d      = 1'b0;
                    rdata_valid_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall drops in DONE so the held instruction retires with the pulse
    assign cpu_stall = resetn & (((state_q == IDLE) & accept) |
                                 ((state_q != IDLE) & (state_q != DONE)));

    assign cpu_rdata       = rdata_q;
    assign cpu_rdata_valid = rdata_valid_q;

    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = addr_q;
    assign bus.arsize  = {1'b0, size_q};
    assign bus.rready  = rready_q;
    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = addr_q;
    assign bus.awsize  = {1'b0, size_q};
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.bready  = bready_q;
endmodule

// File: tb/tb_uncache_ctrl.sv
// Bench for uncache_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level reference model (which handshakes of the current
// access have happened, what data the last load returned).
module tb_uncache_ctrl;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cpu_req_valid = 1'b0;
    logic              cpu_is_uncache = 1'b0;
    logic              cpu_wr = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [STRB_W-1:0] cpu_wstrb = '0;
    logic [1:0]        cpu_size = '0;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rdata_valid;

    always #5 clk = ~clk;

    uncache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    uncache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_is_uncache  (cpu_is_uncache),
        .cpu_wr          (cpu_wr),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_wstrb       (cpu_wstrb),
        .cpu_size        (cpu_size),
        .cpu_stall       (cpu_stall),
        .cpu_rdata       (cpu_rdata),
        .cpu_rdata_valid (cpu_rdata_valid),
        .bus             (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the accepted access and its completed handshakes
    logic              m_busy, m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic [1:0]        m_size;
    logic              m_ar, m_r, m_aw, m_w, m_b;
    logic [DATA_W-1:0] m_last_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 1'b0; m_ar = 1'b0; m_r = 1'b0; m_aw = 1'b0; m_w = 1'b0; m_b = 1'b0;
    endtask

    // Compare every DUT output with the model, then advance the model over the next edge
    task automatic check_cycle();
        logic acc, fin, e_ar, e_r, e_aw, e_w, e_b;
        if (!resetn) begin
            chk("rst_stall", cpu_stall, 0);
            chk("rst_rdvld", cpu_rdata_valid, 0);
            chk("rst_rdata", cpu_rdata, 0);
            chk("rst_arvalid", bus.arvalid, 0);
            chk("rst_rready", bus.rready, 0);
            chk("rst_awvalid", bus.awvalid, 0);
            chk("rst_wvalid", bus.wvalid, 0);
            chk("rst_bready", bus.bready, 0);
            model_clear();
            m_last_rd = '0;
            return;
        end
        acc  = !m_busy && cpu_req_valid && cpu_is_uncache;
        fin  = m_busy && (m_r || m_b);
        e_ar = m_busy && !m_wr && !m_ar;
        e_r  = m_busy && !m_wr && m_ar && !m_r;
        e_aw = m_busy && m_wr && !m_aw;
        e_w  = m_busy && m_wr && !m_w;
        e_b  = m_busy && m_wr && m_aw && m_w && !m_b;
        chk("stall", cpu_stall, acc || (m_busy && !fin));
        chk("rdata_valid", cpu_rdata_valid, fin);
        chk("cpu_rdata", cpu_rdata, m_last_rd);
        chk("arvalid", bus.arvalid, e_ar);
        chk("rready", bus.rready, e_r);
        chk("awvalid", bus.awvalid, e_aw);
        chk("wvalid", bus.wvalid, e_w);
        chk("bready", bus.bready, e_b);
        if (e_ar) begin
            chk("araddr", bus.araddr, m_addr);
            chk("arsize", bus.arsize, {1'b0, m_size});
        end
        if (e_aw) begin
            chk("awaddr", bus.awaddr, m_addr);
            chk("awsize", bus.awsize, {1'b0, m_size});
        end
        if (e_w) begin
            chk("wdata", bus.wdata, m_wdata);
            chk("wstrb", bus.wstrb, m_wstrb);
        end
        if (fin) begin
            model_clear();
        end else if (m_busy) begin
            if (e_ar && bus.arready) m_ar = 1'b1;
            if (e_r && bus.rvalid) begin
                m_r = 1'b1;
                m_last_rd = bus.rdata;
            end
            if (e_aw && bus.awready) m_aw = 1'b1;
            if (e_w && bus.wready)   m_w = 1'b1;
            if (e_b && bus.bvalid)   m_b = 1'b1;
        end else if (acc) begin
            m_busy = 1'b1;
            m_wr = cpu_wr; m_addr = cpu_addr; m_wdata = cpu_wdata;
            m_wstrb = cpu_wstrb; m_size = cpu_size;
        end
    endtask

    // Inputs are set just after a falling edge; check, then move to the next falling edge
    task automatic cyc();
        #1 check_cycle();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    endtask

    task automatic load_seq(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int waits);
        cpu_req_valid = 1'b1; cpu_is_uncache = 1'b1; cpu_wr = 1'b0;
        cpu_addr = a; cpu_size = 2'd2;
        #1 chk("ld_accept_stall", cpu_stall, 1);
        cyc();
        bus.arready = 1'b0;
        repeat (waits) cyc();
        bus.arready = 1'b1;
        cyc();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = d;
        cyc();
        bus.rvalid = 1'b0;
        #1 chk("ld_done_pulse", cpu_rdata_valid, 1);
        chk("ld_done_data", cpu_rdata, d);
        chk("ld_done_stall", cpu_stall, 0);
        cyc();
    endtask

    task automatic store_seq(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [STRB_W-1:0] s, input int t_aw, input int t_w, input int t_b);
        cpu_req_valid = 1'b1; cpu_is_uncache = 1'b1; cpu_wr = 1'b1;
        cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_size = 2'd0;
        for (int t = 0; t <= t_b; t++) begin
            if (t == 1) cpu_req_valid = 1'b0;
            bus.awready = (t == t_aw);
            bus.wready  = (t == t_w);
            bus.bvalid  = (t == t_b);
            cyc();
        end
        bus_idle();
        #1 chk("st_done_pulse", cpu_rdata_valid, 1);
        chk("st_done_stall", cpu_stall, 0);
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] keep;
        bus_idle();
        model_clear();
        m_last_rd = '0;
        @(negedge clk);
        repeat (2) cyc();
        resetn = 1'b1;
        cyc();

        // Single load, minimum latency
        load_seq(32'h1faf_f020, 32'hDEAD_BEEF, 0);
        cpu_req_valid = 1'b0;
        cyc();

        // Stores: aw before w, then w before aw
        store_seq(32'h1faf_f000, 32'h0000_00A5, 4'b0001, 1, 3, 4);
        keep = cpu_rdata;
        chk("st_keeps_rdata", keep, 32'hDEAD_BEEF);
        store_seq(32'h1faf_f004, 32'h1234_5678, 4'b1100, 2, 1, 3);
        cyc();

        // Cached requests are ignored
        cpu_req_valid = 1'b1; cpu_is_uncache = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cpu_wr = 1'($urandom); cpu_addr = $urandom;
            cyc();
        end
        cpu_req_valid = 1'b0;

        // Reset while waiting for read data
        cpu_req_valid = 1'b1; cpu_is_uncache = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'hBFC0_0010;
        cyc();
        cpu_req_valid = 1'b0; bus.arready = 1'b1;
        cyc();
        bus.arready = 1'b0;
        #1 chk("rd_r_rready", bus.rready, 1);
        resetn = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_0001;
        #1 chk("rst_mid_rready", bus.rready, 0);
        chk("rst_mid_stall", cpu_stall, 0);
        cyc();
        cyc();
        resetn = 1'b1; bus_idle();
        cyc();
        cyc();
        load_seq(32'hBFC0_0014, 32'h0BAD_F00D, 1);

        // Back-to-back loads with a slow address channel
        load_seq(32'h1000_0000, 32'hAAAA_5555, 3);
        load_seq(32'h1000_0004, 32'h0102_0304, 3);
        cpu_req_valid = 1'b0;
        cyc();

        // Random traffic with a legal, randomly paced slave
        for (int i = 0; i < 4000; i++) begin
            resetn         = ($urandom_range(0, 599) != 0);
            cpu_req_valid  = ($urandom_range(0, 2) != 0);
            cpu_is_uncache = 1'($urandom);
            cpu_wr         = 1'($urandom);
            cpu_addr       = $urandom;
            cpu_wdata      = $urandom;
            cpu_wstrb      = STRB_W'($urandom);
            cpu_size       = 2'($urandom_range(0, 2));
            bus.arready    = 1'($urandom);
            bus.awready    = 1'($urandom);
            bus.wready     = 1'($urandom);
            bus.rvalid     = m_busy && !m_wr && m_ar && !m_r && ($urandom_range(0, 2) != 0);
            bus.rdata      = $urandom;
            bus.bvalid     = m_busy && m_wr && m_aw && m_w && !m_b && ($urandom_range(0, 2) != 0);
            cyc();
        end
        resetn = 1'b1;
        cpu_req_valid = 1'b0;
        bus_idle();
        repeat (8) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
